// File: rtl/first_nios2_system_sysid_checker.sv
// Reads sysid words 0 (ID) and 1 (timestamp), compares them with build-time values; done 3 + 2*READ_LATENCY + stalls cycles after start.
// Holds av_read/av_address while av_waitrequest stalls, aborting with timeout after TIMEOUT_CYCLES stalled cycles on one read.
module first_nios2_system_sysid_checker #(
    parameter logic [31:0] EXPECTED_ID        = 32'd7,
    parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1383176735,
    parameter int          READ_LATENCY       = 0,
    parameter int          TIMEOUT_CYCLES     = 255
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    output logic        av_address,
    output logic        av_read,
    input  logic        av_waitrequest,
    input  logic [31:0] av_readdata,
    output logic        busy,
    output logic        done,
    output logic        id_ok,
    output logic        ts_ok,
    output logic        timeout,
    output logic [31:0] sys_id,
    output logic [31:0] sys_timestamp
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RD_ID  = 3'd1,
        LAT_ID = 3'd2,
        RD_TS  = 3'd3,
        LAT_TS = 3'd4,
        FINISH = 3'd5
    } state_t;

    localparam logic [1:0]  LAT_LOAD    = 2'(READ_LATENCY);
    // Abort on the stalled cycle that brings the count up to TIMEOUT_CYCLES.
    localparam logic [15:0] STALL_LIMIT = 16'(TIMEOUT_CYCLES - 1);

    state_t      state_q, state_d;
    logic [1:0]  lat_q, lat_d;
    logic [15:0] stall_q, stall_d;
    logic        av_read_q, av_read_d;
    logic        av_address_q, av_address_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        id_ok_q, id_ok_d;
    logic        ts_ok_q, ts_ok_d;
    logic        timeout_q, timeout_d;
    logic [31:0] sys_id_q, sys_id_d;
    logic [31:0] sys_ts_q, sys_ts_d;

    always_comb begin
        state_d   = state_q;
        lat_d     = lat_q;
        stall_d   = stall_q;
        id_ok_d   = id_ok_q;
        ts_ok_d   = ts_ok_q;
        timeout_d = timeout_q;
        sys_id_d  = sys_id_q;
        sys_ts_d  = sys_ts_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = RD_ID;
                    id_ok_d   = 1'b0;
                    ts_ok_d   = 1'b0;
                    timeout_d = 1'b0;
                    sys_id_d  = '0;
                    sys_ts_d  = '0;
                end
            end
            RD_ID, RD_TS: begin
                if (!av_waitrequest) begin
                    if (READ_LATENCY == 0) begin
                        if (state_q == RD_ID) begin
                            sys_id_d = av_readdata;
                            state_d  = RD_TS;
                        end else begin
                            sys_ts_d = av_readdata;
                            state_d  = FINISH;
                        end
                    end else begin
                        lat_d   = LAT_LOAD;
                        state_d = (state_q == RD_ID) ? LAT_ID : LAT_TS;
                    end
                end else begin
                    stall_d = stall_q + 16'd1;
                    if (stall_q == STALL_LIMIT) begin
                        timeout_d = 1'b1;
                        state_d   = FINISH;
                    end
                end
            end
            LAT_ID, LAT_TS: begin
                lat_d = lat_q - 2'd1;
                if (lat_q == 2'd1) begin
                    if (state_q == LAT_ID) begin
                        sys_id_d = av_readdata;
                        state_d  = RD_TS;
                    end else begin
                        sys_ts_d = av_readdata;
                        state_d  = FINISH;
                    end
                end
            end
            FINISH: begin
                id_ok_d = !timeout_q && (sys_id_q == EXPECTED_ID);
                ts_ok_d = !timeout_q && (sys_ts_q == EXPECTED_TIMESTAMP);
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if ((state_d != state_q) && ((state_d == RD_ID) || (state_d == RD_TS))) begin
            stall_d = '0;
        end

        // Strobes are decoded from the next state so every output comes straight off a flop.
        av_read_d    = (state_d == RD_ID) || (state_d == RD_TS);
        av_address_d = (state_d == RD_TS) || (state_d == LAT_TS);
        busy_d       = (state_d != IDLE);
        done_d       = (state_d == FINISH);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            lat_q        <= '0;
            stall_q      <= '0;
            av_read_q    <= 1'b0;
            av_address_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            id_ok_q      <= 1'b0;
            ts_ok_q      <= 1'b0;
            timeout_q    <= 1'b0;
            sys_id_q     <= '0;
            sys_ts_q     <= '0;
        end else begin
            state_q      <= state_d;
            lat_q        <= lat_d;
            stall_q      <= stall_d;
            av_read_q    <= av_read_d;
            av_address_q <= av_address_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            id_ok_q      <= id_ok_d;
            ts_ok_q      <= ts_ok_d;
            timeout_q    <= timeout_d;
            sys_id_q     <= sys_id_d;
            sys_ts_q     <= sys_ts_d;
        end
    end

    assign av_read       = av_read_q;
    assign av_address    = av_address_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign id_ok         = id_ok_q;
    assign ts_ok         = ts_ok_q;
    assign timeout       = timeout_q;
    assign sys_id        = sys_id_q;
    assign sys_timestamp = sys_ts_q;

endmodule

// File: tb/tb_first_nios2_system_sysid_checker.sv
// Directed bench: instance A (zero latency, TIMEOUT_CYCLES=4) and instance B (READ_LATENCY=2) share clock and reset.
module tb_first_nios2_system_sysid_checker;

    localparam logic [31:0] TS_GOOD = 32'd1383176735;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, start, sel, wait_a;
    logic        wait_b = 1'b0;
    logic [31:0] id_val, ts_val;

    logic        addr_a, rd_a, busy_a, done_a, idok_a, tsok_a, to_a;
    logic [31:0] sid_a, sts_a, rdata_a;
    logic        addr_b, rd_b, busy_b, done_b, idok_b, tsok_b, to_b;
    logic [31:0] sid_b, sts_b, rdata_b;

    logic start_a, start_b;
    assign start_a = start & ~sel;
    assign start_b = start & sel;

    assign rdata_a = addr_a ? ts_val : id_val;

    // Slave B returns data two cycles after the accepting cycle, garbage otherwise.
    logic [1:0] pv = 2'b00;
    logic       pa1 = 1'b0, pa2 = 1'b0;
    always @(posedge clk) begin
        pv <= {pv[0], rd_b & ~wait_b};
        if (rd_b) pa1 <= addr_b;
        pa2 <= pa1;
    end
    assign rdata_b = pv[1] ? (pa2 ? ts_val : id_val) : 32'hDEADBEEF;

    first_nios2_system_sysid_checker #(.TIMEOUT_CYCLES(4)) u_dut_a (
        .clock(clk), .reset(reset), .start(start_a),
        .av_address(addr_a), .av_read(rd_a), .av_waitrequest(wait_a), .av_readdata(rdata_a),
        .busy(busy_a), .done(done_a), .id_ok(idok_a), .ts_ok(tsok_a), .timeout(to_a),
        .sys_id(sid_a), .sys_timestamp(sts_a)
    );

    first_nios2_system_sysid_checker #(.READ_LATENCY(2)) u_dut_b (
        .clock(clk), .reset(reset), .start(start_b),
        .av_address(addr_b), .av_read(rd_b), .av_waitrequest(wait_b), .av_readdata(rdata_b),
        .busy(busy_b), .done(done_b), .id_ok(idok_b), .ts_ok(tsok_b), .timeout(to_b),
        .sys_id(sid_b), .sys_timestamp(sts_b)
    );

    logic        rd_m, ad_m, busy_m, done_m, idok_m, tsok_m, to_m;
    logic [31:0] sid_m, sts_m;
    assign rd_m   = sel ? rd_b   : rd_a;
    assign ad_m   = sel ? addr_b : addr_a;
    assign busy_m = sel ? busy_b : busy_a;
    assign done_m = sel ? done_b : done_a;
    assign idok_m = sel ? idok_b : idok_a;
    assign tsok_m = sel ? tsok_b : tsok_a;
    assign to_m   = sel ? to_b   : to_a;
    assign sid_m  = sel ? sid_b  : sid_a;
    assign sts_m  = sel ? sts_b  : sts_a;

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Per-cycle traces indexed by cycle number after the start edge.
    int          done_cyc, n_done;
    logic [31:0] rd_v, ad_v, busy_v, idok_v, zero_v;

    // stall: cycles of waitrequest on the first read (-1 = permanent);
    // restart_cyc / rst_cyc: cycle in which start / reset is pulsed again (0 = never).
    task automatic run(input int stall, input int restart_cyc, input int rst_cyc, input int budget);
        done_cyc = -1;
        n_done   = 0;
        rd_v = '0; ad_v = '0; busy_v = '0; idok_v = '0; zero_v = '0;
        @(negedge clk);
        start  = 1'b1;
        wait_a = (stall != 0);
        for (int c = 1; c <= budget; c++) begin
            @(negedge clk);
            start     = (c == restart_cyc);
            reset     = (c == rst_cyc);
            wait_a    = (stall < 0) || (c <= stall);
            rd_v[c]   = rd_m;
            ad_v[c]   = ad_m;
            busy_v[c] = busy_m;
            idok_v[c] = idok_m;
            zero_v[c] = ~|{rd_m, ad_m, busy_m, done_m, idok_m, tsok_m, to_m, sid_m, sts_m};
            if (done_m) begin
                n_done++;
                if (done_cyc < 0) done_cyc = c;
            end
        end
        start  = 1'b0;
        reset  = 1'b0;
        wait_a = 1'b0;
    endtask

    initial begin
        reset  = 1'b1;
        start  = 1'b0;
        sel    = 1'b0;
        wait_a = 1'b0;
        id_val = 32'd7;
        ts_val = TS_GOOD;
        repeat (3) @(negedge clk);
        check_eq("reset_ctrl", {25'd0, rd_a, addr_a, busy_a, done_a, idok_a, tsok_a, to_a}, 32'd0);
        check_eq("reset_sys_id", sid_a, 32'd0);
        check_eq("reset_sys_ts", sts_a, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Nominal pass, zero latency
        run(0, 0, 0, 8);
        check_eq("nom_done_cyc", done_cyc, 32'd3);
        check_eq("nom_done_cnt", n_done, 32'd1);
        check_eq("nom_rd", rd_v[3:1], 32'b011);
        check_eq("nom_addr", ad_v[2:1], 32'b10);
        check_eq("nom_busy", busy_v[4:1], 32'b0111);
        check_eq("nom_flag_timing", idok_v[4:3], 32'b10);
        check_eq("nom_flags", {idok_m, tsok_m, to_m}, 32'b110);
        check_eq("nom_sys_id", sid_m, 32'd7);
        check_eq("nom_sys_ts", sts_m, TS_GOOD);

        // Mismatched timestamp
        ts_val = 32'h12345678;
        run(0, 0, 0, 8);
        check_eq("mis_flags", {idok_m, tsok_m, to_m}, 32'b100);
        check_eq("mis_sys_ts", sts_m, 32'h12345678);
        check_eq("mis_done_cnt", n_done, 32'd1);
        ts_val = TS_GOOD;

        // Read latency 2 on instance B
        sel = 1'b1;
        run(0, 0, 0, 12);
        check_eq("lat_done_cyc", done_cyc, 32'd7);
        check_eq("lat_done_cnt", n_done, 32'd1);
        check_eq("lat_rd", rd_v[7:1], 32'b0001001);
        check_eq("lat_addr", {ad_v[4], ad_v[1]}, 32'b10);
        check_eq("lat_sys_id", sid_m, 32'd7);
        check_eq("lat_sys_ts", sts_m, TS_GOOD);
        check_eq("lat_flags", {idok_m, tsok_m, to_m}, 32'b110);
        sel = 1'b0;

        // Three stalled cycles on the ID read, below the limit
        run(3, 0, 0, 10);
        check_eq("stall_done_cyc", done_cyc, 32'd6);
        check_eq("stall_rd", rd_v[6:1], 32'b011111);
        check_eq("stall_addr", ad_v[5:1], 32'b10000);
        check_eq("stall_flags", {idok_m, tsok_m, to_m}, 32'b110);

        // Permanent stall -> timeout
        run(-1, 0, 0, 10);
        check_eq("to_rd", rd_v[6:1], 32'b001111);
        check_eq("to_done_cyc", done_cyc, 32'd5);
        check_eq("to_done_cnt", n_done, 32'd1);
        check_eq("to_flags", {idok_m, tsok_m, to_m}, 32'b001);

        // start while busy is ignored
        run(0, 2, 0, 10);
        check_eq("busy_start_done_cnt", n_done, 32'd1);
        check_eq("busy_start_done_cyc", done_cyc, 32'd3);

        // Reset in RD_TS
        run(0, 0, 2, 8);
        check_eq("rst_outputs_zero", zero_v[3], 32'd1);
        check_eq("rst_done_cnt", n_done, 32'd0);
        check_eq("rst_busy", busy_v[5:3], 32'b000);

        // New check after reset
        run(0, 0, 0, 8);
        check_eq("post_rst_done_cyc", done_cyc, 32'd3);
        check_eq("post_rst_flags", {idok_m, tsok_m, to_m}, 32'b110);
        check_eq("post_rst_sys_ts", sts_m, TS_GOOD);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
